// File: rtl/ram_b_arbiter.sv
// ram_b_arbiter: two-port round-robin front end for the single-port RAM_B
// block RAM (1-cycle read latency). Serialises word reads and byte-enabled
// writes; partial writes become an internal read-modify-write.
module ram_b_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  Wr0,
    input  logic                  Wr1,
    input  logic [ADDR_W-1:0]     Addr0,
    input  logic [ADDR_W-1:0]     Addr1,
    input  logic [DATA_W/8-1:0]   BE0,
    input  logic [DATA_W/8-1:0]   BE1,
    input  logic [DATA_W-1:0]     WData0,
    input  logic [DATA_W-1:0]     WData1,
    output logic                  Ack0,
    output logic                  Ack1,
    output logic [DATA_W-1:0]     RData0,
    output logic [DATA_W-1:0]     RData1,
    output logic                  Busy,
    output logic                  Ram_We,
    output logic [ADDR_W-1:0]     Ram_Addr,
    output logic [DATA_W-1:0]     Ram_WData,
    input  logic [DATA_W-1:0]     Ram_RData
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;

    logic [2:0]        state;
    logic              last;
    logic              cmd_port;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BE_W-1:0]   cmd_be;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cap;

    logic              gnt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] merged;
    logic              full_wr;
    logic              we_raw;
    logic              rd_ld;
    logic [DATA_W-1:0] rd_val;

    // Round-robin grant: a lone requester wins, a tie goes to the port
    // that was not served last; then mux that port's command fields.
    always_comb begin
        gnt       = (Req0 && Req1) ? ~last : Req1;
        sel_wr    = gnt ? Wr1    : Wr0;
        sel_addr  = gnt ? Addr1  : Addr0;
        sel_be    = gnt ? BE1    : BE0;
        sel_wdata = gnt ? WData1 : WData0;
    end

    // Byte merge for partial writes: new byte where enabled, else the
    // byte captured from the RAM in CAPT.
    always_comb begin
        merged = cap;
        for (int n = 0; n < BE_W; n++)
            if (cmd_be[n]) merged[8*n +: 8] = cmd_wdata[8*n +: 8];
    end

    // RAM port drive; the write strobe is forced low while reset is held
    // so an interrupted access never commits.
    always_comb begin
        full_wr   = cmd_wr && (&cmd_be);
        we_raw    = ((state == ISSUE) && full_wr) || (state == MERGE);
        Ram_We    = we_raw && !Rst;
        Ram_Addr  = cmd_addr;
        Ram_WData = '0;
        if (Ram_We) Ram_WData = (state == MERGE) ? merged : cmd_wdata;
        Busy      = (state != IDLE);
    end

    // Which value (if any) lands in the granted port's read-data register.
    always_comb begin
        rd_ld  = 1'b0;
        rd_val = cmd_wdata;
        case (state)
            ISSUE: rd_ld = full_wr;
            CAPT:  begin rd_ld = 1'b1; rd_val = Ram_RData; end
            MERGE: begin rd_ld = 1'b1; rd_val = merged;    end
            default: ;
        endcase
    end

    // Sequencer FSM, command registers, read-data and Ack registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_be    <= '0;
            cmd_wdata <= '0;
            cap       <= '0;
            RData0    <= '0;
            RData1    <= '0;
            Ack0      <= 1'b0;
            Ack1      <= 1'b0;
        end else begin
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            if (rd_ld) begin
                if (cmd_port) RData1 <= rd_val;
                else          RData0 <= rd_val;
            end
            case (state)
                IDLE: if (Req0 || Req1) begin
                    last      <= gnt;
                    cmd_port  <= gnt;
                    cmd_wr    <= sel_wr;
                    cmd_addr  <= sel_addr;
                    cmd_be    <= sel_be;
                    cmd_wdata <= sel_wdata;
                    // Empty-mask write completes without touching the RAM.
                    if (sel_wr && (sel_be == '0)) begin
                        state <= ACK;
                        Ack0  <= ~gnt;
                        Ack1  <= gnt;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: if (full_wr) begin
                    state <= ACK;
                    Ack0  <= ~cmd_port;
                    Ack1  <= cmd_port;
                end else begin
                    state <= CAPT;
                end
                CAPT: begin
                    cap <= Ram_RData;
                    if (cmd_wr) begin
                        state <= MERGE;
                    end else begin
                        state <= ACK;
                        Ack0  <= ~cmd_port;
                        Ack1  <= cmd_port;
                    end
                end
                MERGE: begin
                    state <= ACK;
                    Ack0  <= ~cmd_port;
                    Ack1  <= cmd_port;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_b_arbiter.sv
// Bench for ram_b_arbiter: a RAM_B model behind the DUT, a transaction-level
// reference memory, and a per-cycle compare loop plus directed scenarios.
module tb_ram_b_arbiter;
    logic        Clk, Rst;
    logic        Req0, Req1, Wr0, Wr1;
    logic [5:0]  Addr0, Addr1;
    logic [3:0]  BE0, BE1;
    logic [31:0] WData0, WData1;
    logic        Ack0, Ack1, Busy, Ram_We;
    logic [31:0] RData0, RData1, Ram_WData, Ram_RData;
    logic [5:0]  Ram_Addr;

    ram_b_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .BE0(BE0), .BE1(BE1),
        .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
        .Busy(Busy), .Ram_We(Ram_We), .Ram_Addr(Ram_Addr),
        .Ram_WData(Ram_WData), .Ram_RData(Ram_RData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // RAM_B model: 64x32, write-first not needed, 1-cycle registered read.
    logic [31:0] ram [64];
    logic        init_done = 1'b0;
    always @(posedge Clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hA5A5_0000 + i;
            init_done <= 1'b1;
        end else if (Ram_We) begin
            ram[Ram_Addr] <= Ram_WData;
        end
        Ram_RData <= ram[Ram_Addr];
    end

    // Reference state
    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rd [2];
    logic [31:0] pend_rd [2];
    logic [5:0]  cur_addr;
    logic [31:0] cur_wword;
    logic [31:0] last_wdata;
    int          ack_exp;   // -1 none allowed, 0/1 that port, 2 either
    int          we_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Per-cycle comparison of DUT outputs against the reference state.
    task automatic compare_loop();
        forever begin
            @(negedge Clk);
            if (Rst) begin
                check("we_during_rst", {31'd0, Ram_We}, 32'd0);
                continue;
            end
            if (!Ram_We) check("wdata_idle_zero", Ram_WData, 32'd0);
            if (Ram_We) begin
                we_cnt++;
                last_wdata = Ram_WData;
                check("we_addr", {26'd0, Ram_Addr}, {26'd0, cur_addr});
                check("we_wdata", Ram_WData, cur_wword);
            end
            if (Busy) check("busy_addr", {26'd0, Ram_Addr}, {26'd0, cur_addr});
            check("ack_overlap", {31'd0, Ack0 & Ack1}, 32'd0);
            check("ack0_allowed", {31'd0, Ack0 & ~(ack_exp == 0 || ack_exp == 2)}, 32'd0);
            check("ack1_allowed", {31'd0, Ack1 & ~(ack_exp == 1 || ack_exp == 2)}, 32'd0);
            if (Ack0) exp_rd[0] = pend_rd[0];
            if (Ack1) exp_rd[1] = pend_rd[1];
            if (!Busy || Ack0) check("rdata0", RData0, exp_rd[0]);
            if (!Busy || Ack1) check("rdata1", RData1, exp_rd[1]);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic wr, input logic [5:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (port == 0) begin Req0 = req; Wr0 = wr; Addr0 = addr; BE0 = be; WData0 = wd; end
        else           begin Req1 = req; Wr1 = wr; Addr1 = addr; BE1 = be; WData1 = wd; end
    endtask

    // One transaction from an idle DUT; called at a negedge, returns at the
    // negedge after the DUT is back in IDLE. lat = edges from sampling edge
    // to the edge that sees Ack high (0 if Ack never came).
    task automatic do_txn(input int port, input logic wr, input logic [5:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, output int lat);
        logic [31:0] old, nw;
        int exp_lat, exp_we;
        old = ref_mem[addr];
        if (!wr) begin
            nw = old; exp_lat = 3; exp_we = 0; pend_rd[port] = old;
        end else if (be == 4'h0) begin
            nw = old; exp_lat = 1; exp_we = 0; pend_rd[port] = exp_rd[port];
        end else begin
            nw = merge(old, wd, be);
            exp_lat = (be == 4'hF) ? 2 : 4;
            exp_we = 1;
            ref_mem[addr] = nw;
            pend_rd[port] = nw;
        end
        cur_addr = addr; cur_wword = nw; we_cnt = 0; ack_exp = port;
        drive(port, 1'b1, wr, addr, be, wd);
        @(posedge Clk);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if ((port == 0) ? Ack0 : Ack1) begin lat = k + 1; break; end
        end
        drive(port, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        #1;
        check("latency", lat, exp_lat);
        check("we_pulses", we_cnt, exp_we);
        @(negedge Clk);
        ack_exp = -1;
    endtask

    initial begin
        int lat;
        int gap;
        int order[$];
        fork compare_loop(); join_none
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA5A5_0000 + i;
        exp_rd[0] = '0; exp_rd[1] = '0; pend_rd[0] = '0; pend_rd[1] = '0;
        cur_addr = '0; cur_wword = '0; last_wdata = '0; ack_exp = -1; we_cnt = 0;
        Rst = 1'b1;
        drive(0, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        drive(1, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        repeat (2) @(negedge Clk);
        // Reset state
        check("rst_ack", {30'd0, Ack1, Ack0}, 32'd0);
        check("rst_rdata0", RData0, 32'd0);
        check("rst_rdata1", RData1, 32'd0);
        check("rst_ram", {25'd0, Ram_We, Ram_Addr}, 32'd0);
        check("rst_wdata", Ram_WData, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Full write, then read from the other port
        do_txn(0, 1'b1, 6'h05, 4'hF, 32'h1234_5678, lat);
        check("fw_lat_lit", lat, 2);
        check("fw_rdata0_lit", RData0, 32'h1234_5678);
        do_txn(1, 1'b0, 6'h05, 4'h0, 32'h0, lat);
        check("rd_lat_lit", lat, 3);
        check("rd_rdata1_lit", RData1, 32'h1234_5678);

        // Partial write (read-modify-write) and coherent readback
        do_txn(0, 1'b1, 6'h05, 4'b0010, 32'h0000_AB00, lat);
        check("pw_lat_lit", lat, 4);
        check("pw_wdata_lit", last_wdata, 32'h1234_AB78);
        check("pw_rdata0_lit", RData0, 32'h1234_AB78);
        do_txn(1, 1'b0, 6'h05, 4'h0, 32'h0, lat);
        check("pw_readback_lit", RData1, 32'h1234_AB78);

        // Both ports hold reads from reset: strict alternation starting at 0
        Rst = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        drive(0, 1'b1, 1'b0, 6'h05, 4'h0, 32'd0);
        drive(1, 1'b1, 1'b0, 6'h05, 4'h0, 32'd0);
        pend_rd[0] = ref_mem[5]; pend_rd[1] = ref_mem[5];
        cur_addr = 6'h05; ack_exp = 2; we_cnt = 0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        gap = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge Clk);
            #1;
            if (Ack0 || Ack1) begin
                if (order.size() > 0) check("idle_gap", gap, 1);
                order.push_back(Ack1 ? 1 : 0);
                gap = 0;
            end else if (!Busy) begin
                gap++;
            end
        end
        drive(0, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        drive(1, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        check("arb_count", order.size(), 4);
        foreach (order[i]) check("arb_order", order[i], i % 2);
        check("arb_we", we_cnt, 0);
        repeat (2) @(negedge Clk);
        ack_exp = -1;

        // Reset during CAPT of a partial write: no write, no Ack
        cur_addr = 6'h05; we_cnt = 0; ack_exp = -1;
        drive(0, 1'b1, 1'b1, 6'h05, 4'b0010, 32'h0000_CD00);
        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        drive(0, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("capt_rst_we", we_cnt, 0);
        do_txn(0, 1'b0, 6'h05, 4'h0, 32'h0, lat);
        check("capt_rst_readback_lit", RData0, 32'h1234_AB78);

        // Reset during ISSUE of a full write: strobe must be suppressed
        cur_addr = 6'h07; we_cnt = 0; ack_exp = -1;
        drive(1, 1'b1, 1'b1, 6'h07, 4'hF, 32'hDEAD_BEEF);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        drive(1, 1'b0, 1'b0, 6'd0, 4'h0, 32'd0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("issue_rst_we", we_cnt, 0);
        do_txn(1, 1'b0, 6'h07, 4'h0, 32'h0, lat);
        check("issue_rst_readback_lit", RData1, 32'hA5A5_0007);

        // Empty-mask write: 1-cycle Ack, no RAM write, RData held
        do_txn(1, 1'b1, 6'h05, 4'h0, 32'hFFFF_FFFF, lat);
        check("be0_lat_lit", lat, 1);
        check("be0_rdata1_lit", RData1, 32'hA5A5_0007);

        // Partial write at top address with split mask, readback on port 0
        do_txn(1, 1'b1, 6'h3F, 4'b1001, 32'h1122_3344, lat);
        check("pw2_rdata1_lit", RData1, 32'h11A5_0044);
        do_txn(0, 1'b0, 6'h3F, 4'h0, 32'h0, lat);
        check("pw2_readback_lit", RData0, 32'h11A5_0044);

        // Full write at address 0 from port 1, read from port 0
        do_txn(1, 1'b1, 6'h00, 4'hF, 32'hFFFF_0000, lat);
        do_txn(0, 1'b0, 6'h00, 4'h0, 32'h0, lat);
        check("addr0_readback_lit", RData0, 32'hFFFF_0000);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
